// File: rtl/conv_first_to_last_pkg.sv
// -----------------------------------------------------------------------------
// conv_first_to_last_pkg
// Shared types for the first-to-last stream converter.
//   state_e      : hold-register occupancy / pending-flush state
//   encode_state : maps (held_valid, flush_pending) onto state_e
// -----------------------------------------------------------------------------
package conv_first_to_last_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_HELD       = 2'd1,
        ST_HELD_FLUSH = 2'd2
    } state_e;

    function automatic state_e encode_state(input logic held_valid,
                                            input logic flush_pending);
        if (!held_valid)
            return ST_EMPTY;
        else if (flush_pending)
            return ST_HELD_FLUSH;
        else
            return ST_HELD;
    endfunction

endpackage

// File: rtl/conv_first_to_last.sv
// -----------------------------------------------------------------------------
// conv_first_to_last
// Converts a stream whose packet boundaries are marked with 'first' into one
// marked with 'last'. One beat is held back until its successor (which tells
// us whether the held beat ends a packet) or an explicit flush arrives.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   up_valid    in   upstream beat valid
//   up_first    in   upstream beat is first of its packet
//   up_data     in   upstream beat data [width]
//   up_ready    out  upstream beat accepted this cycle (when up_valid)
//   flush       in   pulse: most recently accepted beat ends the stream
//   down_valid  out  downstream beat valid
//   down_last   out  downstream beat is last of its packet
//   down_data   out  downstream beat data [width]
//   down_ready  in   downstream accepts beat
// -----------------------------------------------------------------------------
module conv_first_to_last
    import conv_first_to_last_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    input  logic             up_first,
    input  logic [width-1:0] up_data,
    output logic             up_ready,
    input  logic             flush,
    output logic             down_valid,
    output logic             down_last,
    output logic [width-1:0] down_data,
    input  logic             down_ready
);

    state_e           r_state;
    state_e           w_state_next;
    logic [width-1:0] r_held_data;

    logic w_held_valid;
    logic w_flush_pending;
    logic w_up_xfer;
    logic w_down_xfer;
    logic w_held_valid_next;
    logic w_flush_pending_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // held_data is reset so down_data reads zero straight after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_held_data <= '0;
        end else if (w_up_xfer) begin
            r_held_data <= up_data;
        end
    end

    always_comb begin
        w_held_valid         = (r_state != ST_EMPTY);
        w_flush_pending      = (r_state == ST_HELD_FLUSH);

        // The held beat can only leave once its successor is presented or a
        // flush has marked it as the stream end.
        down_valid           = w_held_valid & (up_valid | w_flush_pending);
        down_last            = down_valid & (w_flush_pending | (up_valid & up_first));
        down_data            = r_held_data;
        up_ready             = ~w_held_valid | down_ready;

        w_up_xfer            = up_valid & up_ready;
        w_down_xfer          = down_valid & down_ready;

        w_held_valid_next    = w_up_xfer | (w_held_valid & ~w_down_xfer);
        // A flush tags whatever sits in the hold register at the end of this
        // cycle, including a beat loaded now. Any down transfer consumes a
        // pending flush: either the register empties, or it is reloaded with
        // a beat the earlier flush did not refer to.
        w_flush_pending_next = w_held_valid_next &
                               (flush | (w_flush_pending & ~w_down_xfer));

        w_state_next         = encode_state(w_held_valid_next, w_flush_pending_next);
    end

endmodule

// File: tb/tb_conv_first_to_last.sv
module tb_conv_first_to_last;

    logic       clock;
    logic       reset;
    logic       up_valid;
    logic       up_first;
    logic [7:0] up_data;
    logic       up_ready;
    logic       flush;
    logic       down_valid;
    logic       down_last;
    logic [7:0] down_data;
    logic       down_ready;

    int errors = 0;
    int checks = 0;

    conv_first_to_last #(.width(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .up_valid   (up_valid),
        .up_first   (up_first),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .flush      (flush),
        .down_valid (down_valid),
        .down_last  (down_last),
        .down_data  (down_data),
        .down_ready (down_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Apply inputs, then let combinational outputs settle before checking.
    task automatic drive(input logic v, input logic f, input logic [7:0] d,
                         input logic fl, input logic dr);
        up_valid   = v;
        up_first   = f;
        up_data    = d;
        flush      = fl;
        down_ready = dr;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic dv, input logic dl, input logic [7:0] dd);
        chk({tag, ".valid"}, {31'd0, down_valid}, {31'd0, dv});
        if (dv) begin
            chk({tag, ".last"}, {31'd0, down_last}, {31'd0, dl});
            chk({tag, ".data"}, {24'd0, down_data}, {24'd0, dd});
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 1);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst.down_valid", {31'd0, down_valid}, 32'd0);
        chk("rst.down_last",  {31'd0, down_last},  32'd0);
        chk("rst.down_data",  {24'd0, down_data},  32'd0);
        chk("rst.up_ready",   {31'd0, up_ready},   32'd1);

        // Single-beat packets A, B, C then flush.
        drive(1, 1, 8'h11, 0, 1); chk_out("t1.a", 0, 0, 8'h00); cyc();
        drive(1, 1, 8'h22, 0, 1); chk_out("t1.b", 1, 1, 8'h11); cyc();
        drive(1, 1, 8'h33, 0, 1); chk_out("t1.c", 1, 1, 8'h22); cyc();
        drive(0, 0, 8'h00, 1, 1); chk_out("t1.fl", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t1.c_out", 1, 1, 8'h33); cyc();
        chk_out("t1.empty", 0, 0, 8'h00);
        chk("t1.up_ready", {31'd0, up_ready}, 32'd1);

        // Multi-beat packet then a single-beat packet.
        drive(1, 1, 8'h01, 0, 1); chk_out("t2.p1", 0, 0, 8'h00); cyc();
        drive(1, 0, 8'h02, 0, 1); chk_out("t2.p2", 1, 0, 8'h01); cyc();
        drive(1, 0, 8'h03, 0, 1); chk_out("t2.p3", 1, 0, 8'h02); cyc();
        drive(1, 1, 8'h10, 0, 1); chk_out("t2.p10", 1, 1, 8'h03); cyc();
        drive(0, 0, 8'h00, 1, 1); chk_out("t2.fl", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t2.out10", 1, 1, 8'h10); cyc();
        chk_out("t2.empty", 0, 0, 8'h00);

        // Backpressure while HELD with a successor waiting.
        drive(1, 1, 8'h41, 0, 1); chk_out("t3.load", 0, 0, 8'h00); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h42, 0, 0);
            chk_out("t3.stall", 1, 0, 8'h41);
            chk("t3.stall.up_ready", {31'd0, up_ready}, 32'd0);
            cyc();
        end
        drive(1, 0, 8'h42, 0, 1);
        chk_out("t3.rel", 1, 0, 8'h41);
        chk("t3.rel.up_ready", {31'd0, up_ready}, 32'd1);
        cyc();
        drive(1, 0, 8'h43, 0, 1); chk_out("t3.next", 1, 0, 8'h42); cyc();
        drive(0, 0, 8'h00, 1, 1); chk_out("t3.fl", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t3.out43", 1, 1, 8'h43); cyc();
        chk_out("t3.empty", 0, 0, 8'h00);

        // Flush in the same cycle a beat enters an empty register.
        drive(1, 1, 8'h55, 1, 1); chk_out("t4.load", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t4.out55", 1, 1, 8'h55); cyc();
        drive(0, 0, 8'h00, 1, 1); chk_out("t4.fl_empty", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t4.after", 0, 0, 8'h00);
        chk("t4.up_ready", {31'd0, up_ready}, 32'd1);
        cyc();

        // HELD_FLUSH with a simultaneous new beat.
        drive(1, 1, 8'h60, 1, 1); chk_out("t5.load", 0, 0, 8'h00); cyc();
        drive(1, 0, 8'h66, 0, 1);
        chk_out("t5.out60", 1, 1, 8'h60);
        chk("t5.up_ready", {31'd0, up_ready}, 32'd1);
        cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t5.nopend", 0, 0, 8'h00); cyc();
        chk_out("t5.nopend2", 0, 0, 8'h00);
        drive(0, 0, 8'h00, 1, 1); cyc();
        drive(0, 0, 8'h00, 0, 0);
        chk_out("t5.bp", 1, 1, 8'h66);
        chk("t5.bp.up_ready", {31'd0, up_ready}, 32'd0);
        cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t5.out66", 1, 1, 8'h66); cyc();
        chk_out("t5.empty", 0, 0, 8'h00);

        // Reset while HELD discards the held beat.
        drive(1, 1, 8'h77, 0, 1); chk_out("t6.load", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk_out("t6.rst", 0, 0, 8'h00);
        chk("t6.rst.up_ready", {31'd0, up_ready}, 32'd1);
        chk("t6.rst.down_data", {24'd0, down_data}, 32'd0);
        drive(1, 1, 8'h88, 1, 1); chk_out("t6.load88", 0, 0, 8'h00); cyc();
        drive(0, 0, 8'h00, 0, 1); chk_out("t6.out88", 1, 1, 8'h88); cyc();
        chk_out("t6.empty", 0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
